unidade_controle: RTL

Multicycle control unit for the RV64 datapath. It sequences instruction fetch, decode, execute, memory access and write-back by driving the write enables and mux selects that are currently hand-driven from the bench: PC, IR, register bank, data memory, Mux1, Mux2 and the PC-source mux. It sits beside the datapath, taking `opcode` from instruction memory and `flag` from the ULA. It also counts retired instructions and halts on unsupported opcodes.

---
 rtl/unidade_controle_if.sv | 33 +++
 rtl/unidade_controle.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/unidade_controle_if.sv
// Control/status bundle between the multicycle control unit and the RV64 datapath.
// The master modport is the controller side; the slave modport is the datapath/bench side.
interface unidade_controle_if #(
  parameter int CNT_W = 16
);
  logic             run;
  logic [6:0]       opcode;
  logic             flag;
  logic             we_pc;
  logic             we_ir;
  logic             we_reg;
  logic             we_mem;
  logic             sel_mux1;
  logic             sel_mux2;
  logic             sel_pc;
  logic             busy;
  logic             illegal;
  logic [CNT_W-1:0] instr_count;

  modport master (
    input  run, opcode, flag,
    output we_pc, we_ir, we_reg, we_mem,
    output sel_mux1, sel_mux2, sel_pc,
    output busy, illegal, instr_count
  );

  modport slave (
    output run, opcode, flag,
    input  we_pc, we_ir, we_reg, we_mem,
    input  sel_mux1, sel_mux2, sel_pc,
    input  busy, illegal, instr_count
  );
endinterface

// File: rtl/unidade_controle.sv
// Multicycle control unit for the RV64 datapath: sequences fetch/decode/execute/
// memory/write-back, counts retired instructions and halts on unsupported opcodes.
//
//   state     | meaning
//   ----------+----------------------------------------------
//   IDLE      | parked, waiting for run
//   FETCH     | load IR from instruction memory
//   DECODE    | classify opcode, latch class
//   EXEC      | ALU settles (R/I)
//   WB_ALU    | write ALU result, PC+4, retire
//   ADDR      | ALU computes rs1 + imm (LD/ST)
//   MEM_WR    | store to data memory, PC+4, retire
//   MEM_RD    | data memory read settles
//   WB_MEM    | write memory data, PC+4, retire
//   BRANCH    | PC <= flag ? PC+imm : PC+4, retire
//   ILLEGAL   | unsupported opcode, sticky until reset
module unidade_controle #(
  parameter int CNT_W = 16
) (
  input  logic                  clock,
  input  logic                  reset_n,
  unidade_controle_if.master    bus
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_WB_ALU,
    S_ADDR,
    S_MEM_WR,
    S_MEM_RD,
    S_WB_MEM,
    S_BRANCH,
    S_ILLEGAL
  } state_t;

  typedef enum logic [2:0] {
    C_R,
    C_I,
    C_LD,
    C_ST,
    C_BR
  } class_t;

  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_LD = 7'b0000011;
  localparam logic [6:0] OP_ST = 7'b0100011;
  localparam logic [6:0] OP_BR = 7'b1100011;

  state_t           state_q, state_d;
  class_t           class_q, class_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  class_t op_class;
  logic   op_valid;
  logic   retire;

  always_comb begin
    op_class = C_R;
    op_valid = 1'b1;
    unique case (bus.opcode)
      OP_R:    op_class = C_R;
      OP_I:    op_class = C_I;
      OP_LD:   op_class = C_LD;
      OP_ST:   op_class = C_ST;
      OP_BR:   op_class = C_BR;
      default: op_valid = 1'b0;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      class_q <= C_R;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      class_q <= class_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    class_d = class_q;
    cnt_d   = cnt_q;
    retire  = 1'b0;
    unique case (state_q)
      S_IDLE:   if (bus.run) state_d = S_FETCH;
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        if (!op_valid) begin
          state_d = S_ILLEGAL;
        end else begin
          class_d = op_class;
          unique case (op_class)
            C_R, C_I:   state_d = S_EXEC;
            C_LD, C_ST: state_d = S_ADDR;
            default:    state_d = S_BRANCH;
          endcase
        end
      end
      S_EXEC:    state_d = S_WB_ALU;
      S_WB_ALU:  retire  = 1'b1;
      S_ADDR:    state_d = (class_q == C_LD) ? S_MEM_RD : S_MEM_WR;
      S_MEM_WR:  retire  = 1'b1;
      S_MEM_RD:  state_d = S_WB_MEM;
      S_WB_MEM:  retire  = 1'b1;
      S_BRANCH:  retire  = 1'b1;
      S_ILLEGAL: state_d = S_ILLEGAL;
      default:   state_d = S_IDLE;
    endcase
    // run is only honoured at instruction boundaries, so a retire with run high skips IDLE
    if (retire) begin
      cnt_d   = cnt_q + 1'b1;
      state_d = bus.run ? S_FETCH : S_IDLE;
    end
  end

  always_comb begin
    bus.we_pc    = 1'b0;
    bus.we_ir    = 1'b0;
    bus.we_reg   = 1'b0;
    bus.we_mem   = 1'b0;
    bus.sel_mux1 = (class_q == C_R) || (class_q == C_BR);
    bus.sel_mux2 = 1'b0;
    bus.sel_pc   = 1'b0;
    bus.busy     = 1'b1;
    bus.illegal  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        bus.busy     = 1'b0;
        bus.sel_mux1 = 1'b1;
      end
      S_FETCH: begin
        bus.we_ir    = 1'b1;
        bus.sel_mux1 = 1'b1;
      end
      S_DECODE: bus.sel_mux1 = 1'b1;
      S_WB_ALU: begin
        bus.we_reg = 1'b1;
        bus.we_pc  = 1'b1;
      end
      S_MEM_WR: begin
        bus.we_mem = 1'b1;
        bus.we_pc  = 1'b1;
      end
      S_WB_MEM: begin
        bus.we_reg   = 1'b1;
        bus.sel_mux2 = 1'b1;
        bus.we_pc    = 1'b1;
      end
      // flag goes straight through; the datapath must hold it stable until the edge
      S_BRANCH: begin
        bus.we_pc  = 1'b1;
        bus.sel_pc = bus.flag;
      end
      S_ILLEGAL: begin
        bus.busy    = 1'b0;
        bus.illegal = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.instr_count = cnt_q;

endmodule
